// File: rtl/piccolo_blk_ctrl.sv
// piccolo_blk_ctrl: sequences 64-bit plaintext blocks into a fixed-key Piccolo-80 core and buffers the ciphertext.
// Latency: CORE_LAT+2 cycles from the accept edge to out_valid; throughput is one block per CORE_LAT+4 cycles.
// Backpressure: one block in flight. in_ready stays low from accept until the ciphertext is taken; out_ready low stalls DONE indefinitely.
//
// Ports:
//   clk, reset          rising-edge clock; synchronous, active-high reset
//   in_valid/in_ready   plaintext handshake, in_data[63:0] (bit 63 = MSB, core bit 0)
//   core_load, core_pt  core load strike (one cycle) and registered plaintext
//   core_ct             combinational ciphertext from the core
//   out_valid/out_ready ciphertext handshake, out_data[63:0] (same bit order as in_data)
//   busy                high in every state except IDLE
//   blk_cnt[15:0]       completed output handshakes, wrapping; present only when
//                       PICCOLO_BLK_CTRL_BLKCNT_EN is defined
module piccolo_blk_ctrl #(
    parameter int CORE_LAT = 2  // edges after the load edge until core_ct is valid, 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic        core_load,
    output logic [63:0] core_pt,
    input  logic [63:0] core_ct,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy
`ifdef PICCOLO_BLK_CTRL_BLKCNT_EN
    ,
    output logic [15:0] blk_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Counter is compared for equality against the latency as a 4-bit value.
    localparam logic [3:0] LAT4 = 4'(CORE_LAT);

    state_t     state;
    logic [3:0] cnt;

    // Control strobes are pure decodes of the registered state, so they
    // change only on clock edges and never depend on the handshake inputs.
    assign in_ready  = (state == IDLE);
    assign core_load = (state == LOAD);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            core_pt   <= 64'd0;
            out_data  <= 64'd0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        core_pt <= in_data;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    // core_load is high during this cycle; the edge ending it
                    // loads core_pt into the core.
                    cnt   <= 4'd0;
                    state <= RUN;
                end
                RUN: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == LAT4) begin
                        out_data  <= core_ct;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // out_data is held after the handshake until the next capture.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PICCOLO_BLK_CTRL_BLKCNT_EN
    // Steps on the same edge that out_valid falls; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            blk_cnt <= 16'd0;
        end else if (state == DONE && out_ready) begin
            blk_cnt <= blk_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_piccolo_blk_ctrl.sv
// Bench for piccolo_blk_ctrl with a stand-in core that has the real core's
// timing (ciphertext valid CORE_LAT edges after the load edge, garbage before).
module tb_piccolo_blk_ctrl;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = 64'd0;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic        core_load;
    logic [63:0] core_pt;
    logic [63:0] core_ct;
    logic        out_valid;
    logic [63:0] out_data;
    logic        busy;
`ifdef PICCOLO_BLK_CTRL_BLKCNT_EN
    logic [15:0] blk_cnt;
`endif

    piccolo_blk_ctrl #(.CORE_LAT(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .core_load (core_load),
        .core_pt   (core_pt),
        .core_ct   (core_ct),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
`ifdef PICCOLO_BLK_CTRL_BLKCNT_EN
        ,
        .blk_cnt   (blk_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Stand-in cipher: the known-answer vector returns the Piccolo-80 result
    // for key 80'h00112233445566778899, everything else a fixed mixing function.
    function automatic logic [63:0] core_fn(input logic [63:0] pt);
        if (pt == 64'h0123456789abcdef) return 64'h8d2bff9935f84056;
        return {pt[31:0] ^ 32'hA5A55A5A, pt[63:32]} + 64'h9E3779B97F4A7C15;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- core stand-in ----------------
    logic [63:0] stub_pt = 64'd0;
    logic [3:0]  stub_k  = 4'd0;
    always @(posedge clk) begin
        if (core_load) begin
            stub_pt <= core_pt;
            stub_k  <= 4'd0;
        end else if (stub_k != 4'hF) begin
            stub_k <= stub_k + 4'd1;
        end
    end
    assign core_ct = (stub_k >= 4'(LAT)) ? core_fn(stub_pt)
                                          : (~core_fn(stub_pt) ^ {60'd0, stub_k});

    // ---------------- transaction-level model ----------------
    // One block in flight: accepted at edge m_acc, captured at edge
    // m_acc+LAT+2, retired at the first later edge with out_ready high.
    int          cyc = 0;
    logic        m_busy = 1'b0;
    logic        m_ov = 1'b0;
    logic [63:0] m_pt = 64'd0;
    logic [63:0] m_od = 64'd0;
    int          m_acc = 0;
    int          m_hs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk("in_ready",  64'(in_ready),  64'(!m_busy));
            chk("busy",      64'(busy),      64'(m_busy));
            chk("core_load", 64'(core_load), 64'(m_busy && cyc == m_acc));
            chk("out_valid", 64'(out_valid), 64'(m_ov));
            chk("out_data",  out_data,       m_od);
            chk("core_pt",   core_pt,        m_pt);
`ifdef PICCOLO_BLK_CTRL_BLKCNT_EN
            chk("blk_cnt",   64'(blk_cnt),   64'(m_hs[15:0]));
`endif
        end
        // Predict the state after the coming edge.
        if (reset) begin
            m_busy = 1'b0;
            m_ov   = 1'b0;
            m_pt   = 64'd0;
            m_od   = 64'd0;
            m_hs   = 0;
        end else if (!m_busy && in_valid) begin
            m_busy = 1'b1;
            m_acc  = cyc + 1;
            m_pt   = in_data;
        end else if (m_busy && m_ov && out_ready) begin
            m_ov   = 1'b0;
            m_busy = 1'b0;
            m_hs++;
        end else if (m_busy && !m_ov && (cyc + 1 == m_acc + LAT + 2)) begin
            m_ov = 1'b1;
            m_od = core_fn(m_pt);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one block, return edges from accept to out_valid and load pulses seen.
    task automatic run_one(input logic [63:0] pt, output int lat, output int loads);
        int w;
        w = 0;
        while (!in_ready && w < 40) begin
            step();
            w++;
        end
        in_valid = 1'b1;
        in_data  = pt;
        step();
        in_valid = 1'b0;
        loads = int'(core_load);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
            loads += int'(core_load);
        end
    endtask

    logic [63:0] bb [8] = '{64'h0000000000000001, 64'hFFFFFFFFFFFFFFFF,
                            64'h0123456789abcdef, 64'hDEADBEEFCAFEF00D,
                            64'h8000000000000000, 64'h5555AAAA5555AAAA,
                            64'h0F0F0F0F0F0F0F0F, 64'h1122334455667788};

    initial begin
        int lat, loads, na, nh, t, acc, hs;
        int acc_t [8];
        logic a_now;

        repeat (3) step();
        reset = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_core_pt",  core_pt,  64'd0);

        // Known answer
        out_ready = 1'b1;
        run_one(64'h0123456789abcdef, lat, loads);
        chk("ka_latency", 64'(lat), 64'd4);
        chk("ka_data", out_data, 64'h8d2bff9935f84056);
        chk("ka_load_pulses", 64'(loads), 64'd1);
        step();
        chk("ka_ready_after", 64'(in_ready), 64'd1);

        // Backpressure: offers during the stall must be ignored
        out_ready = 1'b0;
        run_one(64'hDEADBEEFCAFEF00D, lat, loads);
        chk("bp_latency", 64'(lat), 64'd4);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = 64'hAAAA0000_0000_0000 | 64'(i);
            step();
            chk("bp_data_stable", out_data, core_fn(64'hDEADBEEFCAFEF00D));
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_ready_after", 64'(in_ready), 64'd1);
        chk("bp_valid_after", 64'(out_valid), 64'd0);

        // Back-to-back
        na = 0; nh = 0; t = 0;
        in_valid = 1'b1;
        in_data  = bb[0];
        while ((na < 8 || nh < 8) && t < 300) begin
            a_now = in_valid && in_ready;
            if (out_valid && out_ready && nh < 8) begin
                chk("b2b_order", out_data, core_fn(bb[nh]));
                nh++;
            end
            step();
            t++;
            if (a_now) begin
                acc_t[na] = t;
                na++;
                if (na < 8) in_data = bb[na];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("b2b_accepts", 64'(na), 64'd8);
        chk("b2b_outputs", 64'(nh), 64'd8);
        for (int i = 1; i < 8; i++)
            if (i < na) chk("b2b_gap", 64'(acc_t[i] - acc_t[i-1]), 64'd6);
        step();

        // Reset while cnt == 1
        in_valid = 1'b1;
        in_data  = 64'h0F1E2D3C4B5A6978;
        step();              // accept edge
        in_valid = 1'b0;
        step();              // RUN, cnt 0
        step();              // RUN, cnt 1
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mr_out_valid", 64'(out_valid), 64'd0);
        chk("mr_out_data",  out_data, 64'd0);
        chk("mr_in_ready",  64'(in_ready), 64'd1);
        chk("mr_busy",      64'(busy), 64'd0);
        run_one(64'h1357924680ACE0BD, lat, loads);
        chk("mr_next_latency", 64'(lat), 64'd4);
        chk("mr_next_data", out_data, core_fn(64'h1357924680ACE0BD));
        step();

        // in_valid toggling while busy
        acc = 0; hs = 0; loads = 0;
        for (int i = 0; i < 48; i++) begin
            in_valid = (i % 3 != 0);
            in_data  = 64'h0101010101010101 * 64'(i + 1);
            acc += int'(in_valid && in_ready);
            hs  += int'(out_valid && out_ready);
            step();
            loads += int'(core_load);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            hs += int'(out_valid && out_ready);
            step();
            loads += int'(core_load);
        end
        chk("tog_loads_eq_accepts", 64'(loads), 64'(acc));
        chk("tog_hs_eq_accepts",    64'(hs),    64'(acc));

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
